ex_muldiv_unit: RTL and testbench

// - RV32M execute-stage unit fed by the forwarding unit: muxes operands via ForwardA/ForwardB, runs MUL*/DIV*/REM*.
// - MUL* is a registered one-shot multiply; DIV*/REM* is a radix-2 restoring divider running for XLEN cycles.
// - Drives busy_o to the hazard unit, which stalls IF/ID/IDEX; the result returns to the EX/MEM register with done_o.

---
 rtl/ex_muldiv_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// RV32M execute-stage multiply/divide unit.
// The operands are selected through the forwarding muxes and latched when an instruction is
// accepted. MUL* takes one registered multiply cycle. DIV*/REM* run a radix-2 restoring
// divider for XLEN cycles. Divide-by-zero and signed overflow complete straight from accept.
// Optional feature: define MULDIV_REM_CACHE_EN to keep the last divider result. A repeated
// DIV*/REM* on the same operands and signedness then completes one cycle after accept.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] idex_rs1_data,
  input  logic [XLEN-1:0] idex_rs2_data,
  input  logic [XLEN-1:0] exmem_alu_res,
  input  logic [XLEN-1:0] memwb_wb_data,
  input  logic [1:0]      ForwardA,
  input  logic [1:0]      ForwardB,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]      f3_q, f3_d;      // funct3[1:0]; the state already tells mul from div
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [XLEN-1:0] result_q, result_d;

`ifdef MULDIV_REM_CACHE_EN
  logic            cache_valid_q, cache_valid_d, cache_sgn_q, cache_sgn_d;
  logic [XLEN-1:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic [XLEN-1:0] cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;
`endif

  logic [XLEN-1:0] op_a, op_b, a_mag, b_mag;
  logic            accept, sgn, a_neg, b_neg, div_zero, div_ovf, cache_hit;
  logic            a_sx, b_sx;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     shifted, diff;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, quo_fin, rem_fin;

  // Forwarding muxes for both operands.
  always_comb begin
    unique case (ForwardA)
      2'b10:   op_a = exmem_alu_res;
      2'b01:   op_a = memwb_wb_data;
      default: op_a = idex_rs1_data;
    endcase
    unique case (ForwardB)
      2'b10:   op_b = exmem_alu_res;
      2'b01:   op_b = memwb_wb_data;
      default: op_b = idex_rs2_data;
    endcase
  end

  // Accept-time decode: signedness, magnitudes and the special divide cases.
  always_comb begin
    accept   = (state_q == StIdle) && valid_i && !flush_i;
    sgn      = ~funct3_i[0];
    a_neg    = sgn & op_a[XLEN-1];
    b_neg    = sgn & op_b[XLEN-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = (op_b == '0);
    div_ovf  = sgn && (op_a == IntMin) && (op_b == '1);
`ifdef MULDIV_REM_CACHE_EN
    cache_hit = cache_valid_q && (cache_a_q == op_a) && (cache_b_q == op_b) &&
                (cache_sgn_q == sgn);
`else
    cache_hit = 1'b0;
`endif
  end

  // Multiplier and one restoring-divider step on the latched state.
  always_comb begin
    // Only MULHU (11) treats rs1 as unsigned; MULHSU (10) and MULHU treat rs2 as unsigned.
    a_sx    = (f3_q != 2'b11) & op_a_q[XLEN-1];
    b_sx    = ~f3_q[1] & op_b_q[XLEN-1];
    prod    = {{XLEN{a_sx}}, op_a_q} * {{XLEN{b_sx}}, op_b_q};
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[XLEN]) begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end
    quo_fin = q_neg_q ? -quo_nxt : quo_nxt;
    rem_fin = r_neg_q ? -rem_nxt : rem_nxt;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    f3_d     = f3_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
`ifdef MULDIV_REM_CACHE_EN
    cache_valid_d = cache_valid_q;
    cache_sgn_d   = cache_sgn_q;
    cache_a_d     = cache_a_q;
    cache_b_d     = cache_b_q;
    cache_quo_d   = cache_quo_q;
    cache_rem_d   = cache_rem_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_a_d  = op_a;
          op_b_d  = op_b;
          f3_d    = funct3_i[1:0];
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          cnt_d   = '0;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          if (!funct3_i[2]) begin
            state_d = StMul;
          end else if (div_zero) begin
            state_d  = StDone;
            result_d = funct3_i[1] ? op_a : '1;
          end else if (div_ovf) begin
            state_d  = StDone;
            result_d = funct3_i[1] ? '0 : IntMin;
          end else if (cache_hit) begin
            state_d = StDone;
`ifdef MULDIV_REM_CACHE_EN
            result_d = funct3_i[1] ? cache_rem_q : cache_quo_q;
`endif
          end else begin
            state_d = StDiv;
          end
        end
      end
      StMul: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          state_d  = StDone;
          result_d = (f3_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
      end
      StDiv: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        cnt_d = cnt_q + CntW'(1);
        if (flush_i) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(XLEN - 1)) begin
          state_d  = StDone;
          result_d = f3_q[1] ? rem_fin : quo_fin;
`ifdef MULDIV_REM_CACHE_EN
          cache_valid_d = 1'b1;
          cache_sgn_d   = ~f3_q[0];
          cache_a_d     = op_a_q;
          cache_b_d     = op_b_q;
          cache_quo_d   = quo_fin;
          cache_rem_d   = rem_fin;
`endif
        end
      end
      default: state_d = StIdle;  // StDone always returns to idle, flush or not
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_a_q   <= '0;
      op_b_q   <= '0;
      f3_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
`ifdef MULDIV_REM_CACHE_EN
      cache_valid_q <= 1'b0;
      cache_sgn_q   <= 1'b0;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
      cache_quo_q   <= '0;
      cache_rem_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      f3_q     <= f3_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
`ifdef MULDIV_REM_CACHE_EN
      cache_valid_q <= cache_valid_d;
      cache_sgn_q   <= cache_sgn_d;
      cache_a_q     <= cache_a_d;
      cache_b_q     <= cache_b_d;
      cache_quo_q   <= cache_quo_d;
      cache_rem_q   <= cache_rem_d;
`endif
    end
  end

  // Outputs: done and result come from registers; busy also covers the accept cycle.
  always_comb begin
    busy_o   = accept || (((state_q == StMul) || (state_q == StDiv)) && !flush_i);
    done_o   = (state_q == StDone);
    result_o = result_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, busy length, results and flush/reset aborts.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] idex_rs1_data = '0, idex_rs2_data = '0, exmem_alu_res = '0, memwb_wb_data = '0;
  logic [1:0]  ForwardA = '0, ForwardB = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_REM_CACHE_EN
  localparam int RepLat  = 1;
  localparam int RepBusy = 1;
`else
  localparam int RepLat  = 33;
  localparam int RepBusy = 33;
`endif

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .funct3_i     (funct3_i),
    .idex_rs1_data(idex_rs1_data),
    .idex_rs2_data(idex_rs2_data),
    .exmem_alu_res(exmem_alu_res),
    .memwb_wb_data(memwb_wb_data),
    .ForwardA     (ForwardA),
    .ForwardB     (ForwardB),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .result_o     (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one instruction, then scramble the inputs and measure latency and busy length.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] ex, input logic [31:0] mw, input int exp_lat,
                        input int exp_busy, input logic [31:0] exp_res);
    int lat;
    int bcnt;
    logic [31:0] held;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b1; funct3_i = f3; ForwardA = fa; ForwardB = fb;
    idex_rs1_data = rs1; idex_rs2_data = rs2; exmem_alu_res = ex; memwb_wb_data = mw;
    #1;
    check({tag, " busy@accept"}, {31'd0, busy_o}, 32'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0; ForwardA = ~fa; ForwardB = ~fb; funct3_i = ~f3;
    idex_rs1_data = 32'h5A5A_5A5A; idex_rs2_data = 32'hA5A5_A5A5;
    exmem_alu_res = 32'h1234_5678; memwb_wb_data = 32'h0;
    lat  = 1;
    bcnt = 1;
    while (!done_o && lat < 100) begin
      bcnt += int'(busy_o);
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, bcnt, exp_busy);
    check({tag, " result"}, result_o, exp_res);
    held = result_o;
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, {31'd0, done_o}, 32'd0);
    check({tag, " result held"}, result_o, exp_res);
  endtask

  task automatic count_no_done(input string tag, input int cycles);
    int dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
    end
    check(tag, dones, 0);
  endtask

  initial begin
    #1;
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset done", {31'd0, done_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // tag, f3, fa, fb, rs1, rs2, exmem, memwb, lat, busy, result
    run_op("MUL fwdA", 3'b000, 2'b10, 2'b00, 32'h0, 32'hFFFF_FFFD, 32'd7, 32'h0,
           2, 2, 32'hFFFF_FFEB);
    run_op("MULHU", 3'b011, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
           2, 2, 32'hFFFF_FFFE);
    run_op("MULH", 3'b001, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
           2, 2, 32'h0000_0000);
    run_op("MULHSU", 3'b010, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
           2, 2, 32'hFFFF_FFFF);
    run_op("DIVU fwdB", 3'b101, 2'b00, 2'b01, 32'd100, 32'h0, 32'h0, 32'd7,
           33, 33, 32'd14);
    run_op("REMU", 3'b111, 2'b00, 2'b00, 32'd100, 32'd7, 32'h0, 32'h0,
           RepLat, RepBusy, 32'd2);
    run_op("DIV ovf", 3'b100, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0,
           1, 1, 32'h8000_0000);
    run_op("REM ovf", 3'b110, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0,
           1, 1, 32'h0);
    run_op("REM by0", 3'b110, 2'b00, 2'b00, 32'd5, 32'd0, 32'h0, 32'h0, 1, 1, 32'd5);
    run_op("DIV by0", 3'b100, 2'b00, 2'b00, 32'd5, 32'd0, 32'h0, 32'h0, 1, 1, 32'hFFFF_FFFF);

    // Flush on the 10th divide cycle.
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'b101; ForwardA = 2'b00; ForwardB = 2'b00;
    idex_rs1_data = 32'd1000; idex_rs2_data = 32'd7;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush busy@div", {31'd0, busy_o}, 32'd1);
    flush_i = 1'b1;
    #1;
    check("flush busy", {31'd0, busy_o}, 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    #1;
    check("flush idle busy", {31'd0, busy_o}, 32'd0);
    check("flush done", {31'd0, done_o}, 32'd0);
    count_no_done("flush no done", 40);

    // Reset in the middle of a divide.
    @(negedge clk);
    valid_i = 1'b1; funct3_i = 3'b101; idex_rs1_data = 32'd2000; idex_rs2_data = 32'd3;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst done", {31'd0, done_o}, 32'd0);
    check("rst result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_no_done("rst no done", 40);

    run_op("DIV neg", 3'b100, 2'b00, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0,
           33, 33, 32'hFFFF_FFFD);
    run_op("REM neg", 3'b110, 2'b00, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0,
           RepLat, RepBusy, 32'hFFFF_FFFF);
    // Same operands but unsigned: never a cache hit, full divide.
    run_op("DIVU big", 3'b101, 2'b00, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0,
           33, 33, 32'h7FFF_FFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
